// File: rtl/fpu_cmp_sched.sv
// rtl/fpu_cmp_sched.sv - two-requester scheduler and result register for the shared FPU magnitude comparator
// FPU_CMP_SCHED_RR_EN selects round-robin arbitration; default build is fixed priority to requester 0.
module fpu_cmp_sched #(
  parameter int TAGW = 4
) (
  input  logic            rclk,
  input  logic            rst_l,
  input  logic            req0_vld,
  output logic            req0_rdy,
  input  logic [54:0]     req0_frac1,
  input  logic [54:0]     req0_frac2,
  input  logic [10:0]     req0_exp1,
  input  logic [10:0]     req0_exp2,
  input  logic            req0_sngop,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_vld,
  output logic            req1_rdy,
  input  logic [54:0]     req1_frac1,
  input  logic [54:0]     req1_frac2,
  input  logic [10:0]     req1_exp1,
  input  logic [10:0]     req1_exp2,
  input  logic            req1_sngop,
  input  logic [TAGW-1:0] req1_tag,
  output logic [54:0]     cmp_din1,
  output logic [54:0]     cmp_din2,
  output logic            cmp_sngop,
  output logic            cmp_expadd11,
  output logic            cmp_expeq,
  input  logic            cmp_neq,
  input  logic            cmp_gt,
  input  logic            cmp_gt1,
  output logic            res_vld,
  input  logic            res_rdy,
  output logic            res_rid,
  output logic [TAGW-1:0] res_tag,
  output logic            res_neq,
  output logic            res_gt,
  output logic            res_gt1
);

  logic            adv;
  logic            gnt0;
  logic            gnt1;
  logic            ptr;
  logic            acc;
  logic            win;
  logic            s1_vld;
  logic            s1_rid;
  logic            s1_sngop;
  logic [54:0]     s1_frac1;
  logic [54:0]     s1_frac2;
  logic [10:0]     s1_exp1;
  logic [10:0]     s1_exp2;
  logic [TAGW-1:0] s1_tag;

  // Both stages move together; an empty result register never blocks the pipe.
  assign adv  = ~res_vld | res_rdy;
  assign gnt0 = req0_vld & (~req1_vld | ~ptr);
  assign gnt1 = req1_vld & (~req0_vld | ptr);

  assign req0_rdy = rst_l & adv & gnt0;
  assign req1_rdy = rst_l & adv & gnt1;
  assign acc      = req0_rdy | req1_rdy;
  assign win      = req1_rdy;

`ifdef FPU_CMP_SCHED_RR_EN
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      ptr <= 1'b0;
    end else if (acc) begin
      ptr <= ~win;
    end
  end
`else
  assign ptr = 1'b0;
`endif

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      s1_vld   <= 1'b0;
      s1_rid   <= 1'b0;
      s1_sngop <= 1'b0;
      s1_frac1 <= '0;
      s1_frac2 <= '0;
      s1_exp1  <= '0;
      s1_exp2  <= '0;
      s1_tag   <= '0;
    end else if (adv) begin
      s1_vld <= acc;
      if (acc) begin
        s1_rid   <= win;
        s1_sngop <= win ? req1_sngop : req0_sngop;
        s1_frac1 <= win ? req1_frac1 : req0_frac1;
        s1_frac2 <= win ? req1_frac2 : req0_frac2;
        s1_exp1  <= win ? req1_exp1  : req0_exp1;
        s1_exp2  <= win ? req1_exp2  : req0_exp2;
        s1_tag   <= win ? req1_tag   : req0_tag;
      end
    end
  end

  assign cmp_din1  = s1_frac1;
  assign cmp_din2  = s1_frac2;
  assign cmp_sngop = s1_sngop;
  // Borrow out of the 12-bit exponent difference, i.e. exp2 > exp1.
  assign cmp_expadd11 = (s1_exp2 > s1_exp1);
  assign cmp_expeq    = (s1_exp1 == s1_exp2);

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      res_vld <= 1'b0;
      res_rid <= 1'b0;
      res_tag <= '0;
      res_neq <= 1'b0;
      res_gt  <= 1'b0;
      res_gt1 <= 1'b0;
    end else if (adv) begin
      res_vld <= s1_vld;
      if (s1_vld) begin
        res_rid <= s1_rid;
        res_tag <= s1_tag;
        res_neq <= cmp_neq;
        res_gt  <= cmp_gt;
        res_gt1 <= cmp_gt1;
      end
    end
  end

endmodule

// File: doc/fpu_cmp_sched.md
# fpu_cmp_sched

Two-requester scheduler for the shared FPU fraction/exponent magnitude comparator. It arbitrates between two independent compare requesters and registers the granted operands into the comparator. It derives the exponent-sign and exponent-equal controls, and captures the comparator's result into a tagged, back-pressurable output register. The comparator itself stays combinational and sits between this block's stage-1 register outputs and its stage-2 result inputs.

## Interface
Parameters:
- TAGW, 4, width of the per-request tag carried to the result.

Ports:
- rclk  in  1  clock; all state updates on rising edge.
- rst_l  in  1  synchronous active-low reset.
- req0_vld / req1_vld  in  1  request valid.
- req0_rdy / req1_rdy  out  1  request accepted this cycle when vld&rdy.
- reqN_frac1 / reqN_frac2  in  55  fraction operands 1 and 2, one pair per requester N in {0,1}.
- reqN_exp1 / reqN_exp2  in  11  exponents of operands 1 and 2.
- reqN_sngop  in  1  single-precision operation.
- reqN_tag  in  TAGW  requester tag.
- cmp_din1 / cmp_din2  out  55  stage-1 fraction operands driven to the comparator.
- cmp_sngop  out  1  stage-1 sngop.
- cmp_expadd11  out  1  bit 11 of {1'b0,exp1}-{1'b0,exp2}; high when exp2>exp1.
- cmp_expeq  out  1  exp1==exp2.
- cmp_neq / cmp_gt / cmp_gt1  in  1  comparator results: frac2!=frac1, frac2>frac1, operand2>operand1.
- res_vld  out  1  result valid.
- res_rdy  in  1  consumer accepts the result when res_vld&res_rdy.
- res_rid  out  1  requester index of the result.
- res_tag  out  TAGW  tag of the result.
- res_neq / res_gt / res_gt1  out  1  registered comparator results.

## Operation
- Two-stage pipeline: S1 is the operand register, S2 is the result register. Each stage has a valid bit.
- Advance enable: adv = !res_vld | res_rdy. S1 and S2 load only when adv is high. Otherwise both stages hold, including their valid bits.
- Grant:
  - Only one requester valid: that requester wins.
  - Both valid: the requester selected by priority pointer ptr wins.
  - reqN_rdy = adv & gntN. Ready depends combinationally on req valids and res_rdy.
- ptr update: on each accepted request from requester i, ptr <= ~i. ptr is unchanged when nothing is accepted.
- S1 load on adv:
  - When a request is accepted, S1 takes the winner's operands, sngop, tag, rid, and s1_vld=1.
  - Otherwise s1_vld=0 and the S1 data fields hold.
- Derived controls:
  - cmp_expadd11 and cmp_expeq are computed combinationally from the S1 exponents.
  - cmp_din* and cmp_sngop come straight from the S1 register.
- S2 load on adv: res_vld <= s1_vld. res_* <= cmp_* inputs plus S1 rid/tag. The data fields load only when s1_vld=1.
- Bubbles do not stall: when res_vld=0, adv=1 and S1 drains regardless of res_rdy.
- Reset (rst_l low at an edge):
  - s1_vld=0, res_vld=0, ptr=0.
  - res_rid, res_tag, res_neq, res_gt, res_gt1 = 0.
  - S1 data = 0, so cmp_din1, cmp_din2 and cmp_sngop are 0, cmp_expeq=1 and cmp_expadd11=0.
  - reqN_rdy is forced 0 while rst_l is low.
  - Any in-flight operation is discarded; no partial result is emitted.

## Timing
- Latency: a request accepted at edge N produces res_vld=1 in the cycle after edge N+1 (2 edges).
- Throughput: one request per cycle when res_rdy stays high.
- Stall:
  - res_vld=1 and res_rdy=0 drops both reqN_rdy in the same cycle, and S1/S2 hold.
  - The result and the cmp_* outputs remain stable until res_rdy rises.
- Simultaneous res_rdy and new request: the result is consumed, S1 moves to S2 and the new request enters S1 at the same edge.
- Requesters must hold vld and their data stable until accepted. The block does not retract rdy within a cycle after the inputs settle.

## Configuration
- FPU_CMP_SCHED_RR_EN defined: round-robin arbitration using ptr as described above.
- FPU_CMP_SCHED_RR_EN undefined:
  - Fixed priority, requester 0 always wins contention.
  - ptr logic is removed; ptr reads as constant 0.
  - Requester 1 can starve.

## Test plan
- Single request: req0 frac1=0x10, frac2=0x20, exp1=exp2=0x3FF, sngop=0, tag=5, with cmp_gt=1 and cmp_gt1=1 from the comparator model. Required: cmp_expeq=1 one cycle after acceptance, then res_vld=1, rid=0, tag=5, gt=1, gt1=1 two cycles after acceptance.
- Exponent control: exp1=0x3FE, exp2=0x3FF. Required: cmp_expadd11=1, cmp_expeq=0. Swapped exponents: required cmp_expadd11=0.
- Contention: both requesters valid continuously for 4 cycles with RR enabled. Required: grants in order 0,1,0,1 and res_rid sequence 0,1,0,1. Same stimulus with the macro undefined: required 0,0,0,0 and req1_rdy=0 throughout.
- Backpressure: 3 back-to-back requests with res_rdy held low from cycle 2 for 5 cycles. Required: both req_rdy=0 during the stall, res_* stable, no result lost or duplicated, then 3 results in order after res_rdy rises.
- Bubble drain: one request while res_vld=0 and res_rdy=0. Required: the result reaches S2 and then holds until res_rdy.
- Reset mid-flight: rst_l low for one edge with S1 and S2 both valid. Required: res_vld=0 and ptr=0 the next cycle, and no stale result appears afterwards.
